// File: rtl/udp_sched_pkg.sv
// Shared state encoding and length constants for the UDP transmit scheduler.
// The default UDP length covers the 8-byte header plus the 20-byte boot message.
package udp_sched_pkg;

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    REQ,
    WAIT
  } sched_state_t;

  localparam int unsigned IP_HDR_LEN      = 20;
  localparam int unsigned UDP_HDR_LEN     = 8;
  localparam int unsigned BOOT_MSG_BYTES  = 20;
  localparam int unsigned DEFAULT_UDP_LEN = UDP_HDR_LEN + BOOT_MSG_BYTES;
  localparam int unsigned DEFAULT_IP_LEN  = DEFAULT_UDP_LEN + IP_HDR_LEN;

endpackage

// File: rtl/beacon_timer.sv
// Free-running period counter emitting a one-cycle tick on the last count of each period.
// A period of 0 removes the counter and never ticks.
module beacon_timer #(
  parameter int unsigned PERIOD = 125000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  if (PERIOD == 0) begin : g_off
    assign tick = 1'b0;
  end else begin : g_on
    localparam int unsigned   CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
      if (reset) begin
        count <= '0;
      end else if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end

    assign tick = (count == LAST);
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Owns the payload RAM write port (boot preload plus rx pass-through) and sequences
// beacon and echo transmit requests to the UDP engine.
module udp_tx_scheduler
  import udp_sched_pkg::*;
#(
  parameter int unsigned AW            = 9,
  parameter int unsigned DW            = 32,
  parameter int unsigned BOOT_WORDS    = 5,
  parameter int unsigned BOOT_BASE     = 1,
  parameter int unsigned BEACON_PERIOD = 125000000,
  parameter int unsigned DEF_UDP_LEN   = udp_sched_pkg::DEFAULT_UDP_LEN,
  parameter int unsigned DEF_IP_LEN    = DEF_UDP_LEN + udp_sched_pkg::IP_HDR_LEN
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] boot_addr_o,
  input  logic [DW-1:0] boot_data_i,
  input  logic          rx_wr_en_i,
  input  logic [AW-1:0] rx_wr_addr_i,
  input  logic [DW-1:0] rx_wr_data_i,
  input  logic          rx_done_i,
  input  logic [15:0]   rx_data_len_i,
  input  logic [15:0]   rx_total_len_i,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  output logic          tx_req_o,
  input  logic          tx_ack_i,
  input  logic          tx_busy_i,
  output logic [15:0]   tx_data_len_o,
  output logic [15:0]   tx_total_len_o,
  output logic          boot_done_o,
  output logic          echo_o
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BOOT_BASE);
  localparam logic [AW-1:0] LAST_K    = AW'(BOOT_WORDS - 1);
  localparam logic [15:0]   DEF_UDP   = 16'(DEF_UDP_LEN);
  localparam logic [15:0]   DEF_IP    = 16'(DEF_IP_LEN);

  sched_state_t  state, state_next;
  logic [AW-1:0] boot_k;
  logic          echo_pend, beacon_pend, wait_armed;
  logic [15:0]   rx_data_len_q, rx_total_len_q;
  logic          beacon_tick, boot_wr, take_echo, take_beacon;

  beacon_timer #(
    .PERIOD(BEACON_PERIOD)
  ) u_beacon_timer (
    .clk  (clk),
    .reset(reset),
    .tick (beacon_tick)
  );

  assign boot_addr_o = boot_k;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // An rx write steals the port, so the boot word is simply retried next cycle.
  always_comb begin
    state_next  = state;
    boot_wr     = 1'b0;
    take_echo   = 1'b0;
    take_beacon = 1'b0;
    unique case (state)
      BOOT: begin
        if (BOOT_WORDS == 0) begin
          state_next = IDLE;
        end else if (!rx_wr_en_i) begin
          boot_wr = 1'b1;
          if (boot_k == LAST_K) state_next = IDLE;
        end
      end
      IDLE: begin
        if (echo_pend) begin
          take_echo  = 1'b1;
          state_next = REQ;
        end else if (beacon_pend) begin
          take_beacon = 1'b1;
          state_next  = REQ;
        end
      end
      REQ:  if (tx_ack_i) state_next = WAIT;
      WAIT: if (wait_armed && !tx_busy_i) state_next = IDLE;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      boot_k         <= '0;
      wait_armed     <= 1'b0;
      echo_pend      <= 1'b0;
      beacon_pend    <= 1'b0;
      rx_data_len_q  <= '0;
      rx_total_len_q <= '0;
      ram_we_o       <= 1'b0;
      ram_addr_o     <= '0;
      ram_din_o      <= '0;
      tx_req_o       <= 1'b0;
      tx_data_len_o  <= DEF_UDP;
      tx_total_len_o <= DEF_IP;
      boot_done_o    <= 1'b0;
      echo_o         <= 1'b0;
    end else begin
      wait_armed <= (state == WAIT);
      if (boot_wr) boot_k <= boot_k + 1'b1;

      ram_we_o <= rx_wr_en_i | boot_wr;
      if (rx_wr_en_i) begin
        ram_addr_o <= rx_wr_addr_i;
        ram_din_o  <= rx_wr_data_i;
      end else if (boot_wr) begin
        ram_addr_o <= BASE_ADDR + boot_k;
        ram_din_o  <= boot_data_i;
      end

      if (state == BOOT && state_next == IDLE) boot_done_o <= 1'b1;

      // A fresh rx_done re-arms the echo even on the cycle an older one is taken.
      if (rx_done_i) begin
        echo_pend      <= 1'b1;
        rx_data_len_q  <= rx_data_len_i;
        rx_total_len_q <= rx_total_len_i;
      end else if (take_echo) begin
        echo_pend <= 1'b0;
      end

      if (beacon_tick) begin
        beacon_pend <= 1'b1;
      end else if (take_beacon) begin
        beacon_pend <= 1'b0;
      end

      tx_req_o <= (state_next == REQ);
      if (take_echo) begin
        tx_data_len_o  <= rx_data_len_q;
        tx_total_len_o <= rx_total_len_q;
        echo_o         <= 1'b1;
      end else if (take_beacon) begin
        tx_data_len_o  <= DEF_UDP;
        tx_total_len_o <= DEF_IP;
        echo_o         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Randomized bench for udp_tx_scheduler: boot preload with rx collisions, beacon timing,
// echo last-wins and priority, and reset in the middle of a transmit.
module tb_udp_tx_scheduler;

  localparam int AW         = 9;
  localparam int DW         = 32;
  localparam int BOOT_WORDS = 5;
  localparam int BOOT_BASE  = 1;
  localparam int PERIOD     = 100;
  localparam int DEF_UDP    = 28;
  localparam int DEF_IP     = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] boot_addr_o;
  logic [DW-1:0] boot_data_i;
  logic          rx_wr_en_i;
  logic [AW-1:0] rx_wr_addr_i;
  logic [DW-1:0] rx_wr_data_i;
  logic          rx_done_i;
  logic [15:0]   rx_data_len_i;
  logic [15:0]   rx_total_len_i;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_din_o;
  logic          tx_req_o;
  logic          tx_ack_i;
  logic          tx_busy_i;
  logic [15:0]   tx_data_len_o;
  logic [15:0]   tx_total_len_o;
  logic          boot_done_o;
  logic          echo_o;

  logic [DW-1:0] rom [BOOT_WORDS];
  int testCount = 0;
  int failCount = 0;
  int edgeCount = 0;

  udp_tx_scheduler #(
    .AW(AW), .DW(DW), .BOOT_WORDS(BOOT_WORDS), .BOOT_BASE(BOOT_BASE),
    .BEACON_PERIOD(PERIOD), .DEF_UDP_LEN(DEF_UDP), .DEF_IP_LEN(DEF_IP)
  ) dut (
    .clk(clk), .reset(reset),
    .boot_addr_o(boot_addr_o), .boot_data_i(boot_data_i),
    .rx_wr_en_i(rx_wr_en_i), .rx_wr_addr_i(rx_wr_addr_i), .rx_wr_data_i(rx_wr_data_i),
    .rx_done_i(rx_done_i), .rx_data_len_i(rx_data_len_i), .rx_total_len_i(rx_total_len_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o),
    .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i), .tx_busy_i(tx_busy_i),
    .tx_data_len_o(tx_data_len_o), .tx_total_len_o(tx_total_len_o),
    .boot_done_o(boot_done_o), .echo_o(echo_o)
  );

  always #5 clk = ~clk;

  // Edge 0 is the last edge with reset high; beacon ticks are sampled on multiples of PERIOD.
  always @(posedge clk) begin
    if (reset) edgeCount <= 0;
    else       edgeCount <= edgeCount + 1;
  end

  initial begin
    rom[0] = "HELL";
    rom[1] = "O AL";
    rom[2] = "INX ";
    rom[3] = "AV60";
    rom[4] = "45\r\n";
  end

  assign boot_data_i = (32'(boot_addr_o) < BOOT_WORDS) ? rom[boot_addr_o[2:0]] : '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (edge %0d)", tag, observed, expected, edgeCount);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rstRamWe", 32'(ram_we_o), 0);
    checkOutput("rstRamAddr", 32'(ram_addr_o), 0);
    checkOutput("rstRamDin", ram_din_o, 0);
    checkOutput("rstTxReq", 32'(tx_req_o), 0);
    checkOutput("rstDataLen", 32'(tx_data_len_o), DEF_UDP);
    checkOutput("rstTotalLen", 32'(tx_total_len_o), DEF_IP);
    checkOutput("rstBootDone", 32'(boot_done_o), 0);
    checkOutput("rstEcho", 32'(echo_o), 0);
    checkOutput("rstBootAddr", 32'(boot_addr_o), 0);
  endtask

  // One cycle with a random rx RAM write, checked at the registered write port.
  task automatic stepCycle();
    bit            en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    en = ($urandom_range(0, 1) == 1);
    a  = AW'($urandom);
    d  = $urandom;
    rx_wr_en_i = en; rx_wr_addr_i = a; rx_wr_data_i = d;
    @(posedge clk); #1;
    rx_wr_en_i = 1'b0;
    checkOutput("rxWe", 32'(ram_we_o), 32'(en));
    if (en) begin
      checkOutput("rxAddr", 32'(ram_addr_o), 32'(a));
      checkOutput("rxData", ram_din_o, d);
    end
  endtask

  // One cycle carrying an rx_done pulse; lengths are scrambled afterwards.
  task automatic applyStimulus(input logic [15:0] dataLen, input logic [15:0] totalLen);
    rx_done_i = 1'b1; rx_data_len_i = dataLen; rx_total_len_i = totalLen;
    @(posedge clk); #1;
    rx_done_i = 1'b0;
    rx_data_len_i = 16'($urandom); rx_total_len_i = 16'($urandom);
  endtask

  // Boot model: each cycle either the rx write or the next boot word owns the port.
  task automatic runBoot(input bit collide);
    int            k = 0;
    int            cycles = 0;
    bit            didCollide = 0;
    bit            rxEn;
    logic [AW-1:0] rxAddr;
    logic [DW-1:0] rxData;
    while (k < BOOT_WORDS && cycles < 40) begin
      checkOutput("bootAddr", 32'(boot_addr_o), k);
      if (collide && k == 2 && !didCollide) begin
        rxEn = 1'b1; rxAddr = 9'h040; didCollide = 1'b1;
      end else begin
        rxEn = collide && ($urandom_range(0, 3) == 0);
        rxAddr = AW'($urandom);
      end
      rxData = $urandom;
      rx_wr_en_i = rxEn; rx_wr_addr_i = rxAddr; rx_wr_data_i = rxData;
      @(posedge clk); #1;
      cycles++;
      rx_wr_en_i = 1'b0;
      checkOutput("bootWe", 32'(ram_we_o), 1);
      if (rxEn) begin
        checkOutput("collAddr", 32'(ram_addr_o), 32'(rxAddr));
        checkOutput("collData", ram_din_o, rxData);
      end else begin
        checkOutput("bootWrAddr", 32'(ram_addr_o), (BOOT_BASE + k) % (1 << AW));
        checkOutput("bootWrData", ram_din_o, rom[k]);
        k++;
      end
      checkOutput("bootDone", 32'(boot_done_o), 32'(k == BOOT_WORDS));
    end
    checkOutput("bootCount", k, BOOT_WORDS);
    @(posedge clk); #1;
    checkOutput("bootQuietWe", 32'(ram_we_o), 0);
    checkOutput("bootDoneSticky", 32'(boot_done_o), 1);
  endtask

  task automatic waitReq(input int maxCycles, output int riseEdge);
    int c = 0;
    while (!tx_req_o && c < maxCycles) begin
      stepCycle();
      c++;
    end
    checkOutput("reqSeen", 32'(tx_req_o), 1);
    riseEdge = edgeCount;
  endtask

  // Checks the request contents, holds it, acks, then plays busy; busyEnd is the edge busy drops.
  task automatic serveTx(input logic [15:0] expData, input logic [15:0] expTotal,
                         input bit expEcho, output int busyEnd);
    int holdCycles = $urandom_range(1, 5);
    int busyCycles = $urandom_range(1, 6);
    checkOutput("txDataLen", 32'(tx_data_len_o), 32'(expData));
    checkOutput("txTotalLen", 32'(tx_total_len_o), 32'(expTotal));
    checkOutput("txEcho", 32'(echo_o), 32'(expEcho));
    repeat (holdCycles) begin
      stepCycle();
      checkOutput("reqHold", 32'(tx_req_o), 1);
      checkOutput("holdDataLen", 32'(tx_data_len_o), 32'(expData));
      checkOutput("holdTotalLen", 32'(tx_total_len_o), 32'(expTotal));
    end
    tx_ack_i = 1'b1;
    stepCycle();
    tx_ack_i = 1'b0;
    checkOutput("reqDrop", 32'(tx_req_o), 0);
    stepCycle();
    tx_busy_i = 1'b1;
    repeat (busyCycles) begin
      stepCycle();
      checkOutput("noReqBusy", 32'(tx_req_o), 0);
    end
    tx_busy_i = 1'b0;
    busyEnd = edgeCount;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at edge %0d", edgeCount);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int rise, busyEnd, doneEdge;
    logic [15:0] lenA, totA;
    reset = 1'b1;
    rx_wr_en_i = 1'b0; rx_wr_addr_i = '0; rx_wr_data_i = '0;
    rx_done_i = 1'b0; rx_data_len_i = '0; rx_total_len_i = '0;
    tx_ack_i = 1'b0; tx_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues();
    reset = 1'b0;

    runBoot(1'b1);

    waitReq(200, rise);
    checkOutput("beacon1Edge", rise, PERIOD + 1);
    serveTx(16'(DEF_UDP), 16'(DEF_IP), 1'b0, busyEnd);
    waitReq(200, rise);
    checkOutput("beacon2Edge", rise, 2 * PERIOD + 1);
    serveTx(16'(DEF_UDP), 16'(DEF_IP), 1'b0, busyEnd);

    applyStimulus(16'd40, 16'd60);
    doneEdge = edgeCount;
    waitReq(20, rise);
    checkOutput("echo1Edge", rise, doneEdge + 1);
    lenA = 16'($urandom); totA = 16'($urandom);
    applyStimulus(lenA, totA);
    checkOutput("rearmReq", 32'(tx_req_o), 1);
    checkOutput("rearmLen", 32'(tx_data_len_o), 40);
    applyStimulus(16'd12, 16'd32);
    checkOutput("rearmReq2", 32'(tx_req_o), 1);
    checkOutput("rearmTotal", 32'(tx_total_len_o), 60);
    serveTx(16'd40, 16'd60, 1'b1, busyEnd);
    waitReq(20, rise);
    checkOutput("echoLastEdge", rise, busyEnd + 2);
    serveTx(16'd12, 16'd32, 1'b1, busyEnd);

    waitReq(200, rise);
    checkOutput("beacon3Edge", rise, 3 * PERIOD + 1);
    serveTx(16'(DEF_UDP), 16'(DEF_IP), 1'b0, busyEnd);

    while (edgeCount < 4 * PERIOD - 1) begin
      stepCycle();
      checkOutput("quietReq", 32'(tx_req_o), 0);
    end
    lenA = 16'($urandom); totA = 16'($urandom);
    applyStimulus(lenA, totA);
    waitReq(20, rise);
    checkOutput("prioEchoEdge", rise, 4 * PERIOD + 1);
    serveTx(lenA, totA, 1'b1, busyEnd);
    waitReq(20, rise);
    checkOutput("prioBeaconEdge", rise, busyEnd + 2);
    serveTx(16'(DEF_UDP), 16'(DEF_IP), 1'b0, busyEnd);

    lenA = 16'($urandom); totA = 16'($urandom);
    applyStimulus(lenA, totA);
    waitReq(20, rise);
    checkOutput("preRstLen", 32'(tx_data_len_o), 32'(lenA));
    checkOutput("preRstEcho", 32'(echo_o), 1);
    tx_ack_i = 1'b1;
    stepCycle();
    tx_ack_i = 1'b0;
    tx_busy_i = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    rx_wr_en_i = 1'b1; rx_wr_addr_i = AW'($urandom); rx_wr_data_i = $urandom;
    @(posedge clk); #1;
    rx_wr_en_i = 1'b0;
    checkResetValues();
    reset = 1'b0;
    tx_busy_i = 1'b0;
    runBoot(1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
